// File: rtl/i2c_slave.sv
// rtl/i2c_slave.sv - 7-bit address I2C target with oversampled SCL/SDA and open-drain SDA.
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h42
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl,
  inout  wire        sda,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       busy,
  output logic       nack_seen
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, WAIT_STOP
  } state_t;

  state_t     state, state_nx;
  logic [1:0] scl_sync, sda_sync;
  logic       scl_d, sda_d;
  logic [2:0] bit_cnt, bit_cnt_nx;
  logic [7:0] shift, shift_nx;
  logic [7:0] rx_data_nx;
  logic       rw, rw_nx;
  logic       byte_done, byte_done_nx;
  logic       sda_oe, sda_oe_nx;
  logic       busy_nx, rx_valid_nx, tx_req_nx, nack_nx;
  logic       scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;

  assign sda = sda_oe ? 1'b0 : 1'bz;

  assign scl_s     = scl_sync[1];
  assign sda_s     = sda_sync[1];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & sda_d & ~sda_s;
  assign stop_det  = scl_s & ~sda_d & sda_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl};
      sda_sync <= {sda_sync[0], sda};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bit_cnt   <= 3'd0;
      shift     <= 8'd0;
      rw        <= 1'b0;
      byte_done <= 1'b0;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      rx_data   <= 8'd0;
      rx_valid  <= 1'b0;
      tx_req    <= 1'b0;
      nack_seen <= 1'b0;
    end else begin
      state     <= state_nx;
      bit_cnt   <= bit_cnt_nx;
      shift     <= shift_nx;
      rw        <= rw_nx;
      byte_done <= byte_done_nx;
      sda_oe    <= sda_oe_nx;
      busy      <= busy_nx;
      rx_data   <= rx_data_nx;
      rx_valid  <= rx_valid_nx;
      tx_req    <= tx_req_nx;
      nack_seen <= nack_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    bit_cnt_nx   = bit_cnt;
    shift_nx     = shift;
    rw_nx        = rw;
    byte_done_nx = byte_done;
    sda_oe_nx    = sda_oe;
    busy_nx      = busy;
    rx_data_nx   = rx_data;
    rx_valid_nx  = 1'b0;
    tx_req_nx    = 1'b0;
    nack_nx      = 1'b0;

    // Bus conditions win over whatever the byte engine was doing.
    if (start_det) begin
      state_nx     = ADDR;
      bit_cnt_nx   = 3'd0;
      byte_done_nx = 1'b0;
      sda_oe_nx    = 1'b0;
    end else if (stop_det) begin
      state_nx     = IDLE;
      byte_done_nx = 1'b0;
      busy_nx      = 1'b0;
      sda_oe_nx    = 1'b0;
    end else begin
      case (state)
        IDLE: ;
        ADDR: begin
          if (scl_rise) begin
            shift_nx   = {shift[6:0], sda_s};
            bit_cnt_nx = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) byte_done_nx = 1'b1;
          end else if (scl_fall && byte_done) begin
            byte_done_nx = 1'b0;
            if (shift[7:1] == SLAVE_ADDR) begin
              rw_nx     = shift[0];
              sda_oe_nx = 1'b1;
              busy_nx   = 1'b1;
              state_nx  = ADDR_ACK;
            end else begin
              busy_nx  = 1'b0;
              state_nx = WAIT_STOP;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            bit_cnt_nx = 3'd0;
            if (!rw) begin
              sda_oe_nx = 1'b0;
              state_nx  = WRITE;
            end else begin
              tx_req_nx = 1'b1;
              shift_nx  = tx_data;
              sda_oe_nx = ~tx_data[7];
              state_nx  = READ;
            end
          end
        end
        WRITE: begin
          if (scl_rise) begin
            shift_nx   = {shift[6:0], sda_s};
            bit_cnt_nx = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              rx_data_nx   = {shift[6:0], sda_s};
              rx_valid_nx  = 1'b1;
              byte_done_nx = 1'b1;
            end
          end else if (scl_fall && byte_done) begin
            byte_done_nx = 1'b0;
            sda_oe_nx    = 1'b1;
            state_nx     = WRITE_ACK;
          end
        end
        WRITE_ACK: begin
          if (scl_fall) begin
            sda_oe_nx  = 1'b0;
            bit_cnt_nx = 3'd0;
            state_nx   = WRITE;
          end
        end
        READ: begin
          // bit7 is already on the bus; each fall shifts the next bit into shift[7].
          if (scl_fall) begin
            if (bit_cnt == 3'd7) begin
              sda_oe_nx  = 1'b0;
              bit_cnt_nx = 3'd0;
              state_nx   = READ_ACK;
            end else begin
              shift_nx   = {shift[6:0], 1'b0};
              sda_oe_nx  = ~shift[6];
              bit_cnt_nx = bit_cnt + 3'd1;
            end
          end
        end
        READ_ACK: begin
          if (scl_rise) begin
            if (!sda_s) begin
              byte_done_nx = 1'b1;
            end else begin
              nack_nx  = 1'b1;
              state_nx = WAIT_STOP;
            end
          end else if (scl_fall && byte_done) begin
            byte_done_nx = 1'b0;
            tx_req_nx    = 1'b1;
            shift_nx     = tx_data;
            sda_oe_nx    = ~tx_data[7];
            bit_cnt_nx   = 3'd0;
            state_nx     = READ;
          end
        end
        WAIT_STOP: sda_oe_nx = 1'b0;
        default: state_nx = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_slave.sv
// tb/tb_i2c_slave.sv - directed bench for i2c_slave with a transaction-level expectation model.
module tb_i2c_slave;

  localparam int Q = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       m_low = 1'b0;
  logic [7:0] tx_data = 8'h00;
  wire        sda;
  logic [7:0] rx_data;
  logic       rx_valid, tx_req, busy, nack_seen;

  pullup (sda);
  assign sda = m_low ? 1'b0 : 1'bz;

  i2c_slave #(.SLAVE_ADDR(7'h42)) dut (
    .clk(clk), .rst_n(rst_n), .scl(scl), .sda(sda),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data),
    .tx_req(tx_req), .busy(busy), .nack_seen(nack_seen)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Observations gathered every cycle.
  logic [7:0] got_rx_q[$];
  int rx_cnt = 0, tx_cnt = 0, nack_cnt = 0, width_viol = 0;
  logic prev_rx_valid = 1'b0, prev_tx_req = 1'b0, prev_nack = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid) begin
        rx_cnt++;
        got_rx_q.push_back(rx_data);
      end
      if (tx_req) tx_cnt++;
      if (nack_seen) nack_cnt++;
      if ((rx_valid && prev_rx_valid) || (tx_req && prev_tx_req) || (nack_seen && prev_nack))
        width_viol++;
    end
    prev_rx_valid = rx_valid;
    prev_tx_req   = tx_req;
    prev_nack     = nack_seen;
  end

  // Expectation model state.
  logic       exp_busy = 1'b0;
  logic       selected = 1'b0;
  logic [7:0] exp_rx_q[$];
  int exp_tx_cnt = 0, exp_nack_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clock_bit(input logic drive, input logic exp_line, input string name);
    m_low = ~drive;
    wait_clk(Q);
    scl = 1'b1;
    wait_clk(Q);
    chk({name, " line"}, {31'd0, sda}, {31'd0, exp_line});
    chk({name, " busy"}, {31'd0, busy}, {31'd0, exp_busy});
    wait_clk(Q);
    scl = 1'b0;
    wait_clk(Q);
  endtask

  task automatic i2c_start();
    if (scl == 1'b0) begin
      m_low = 1'b0;
      wait_clk(Q);
      scl = 1'b1;
      wait_clk(Q);
    end
    m_low = 1'b1;
    wait_clk(Q);
    scl = 1'b0;
    wait_clk(Q);
  endtask

  task automatic i2c_stop();
    m_low = 1'b1;
    wait_clk(Q);
    scl = 1'b1;
    wait_clk(Q);
    m_low = 1'b0;
    wait_clk(Q);
    exp_busy = 1'b0;
    selected = 1'b0;
    chk("stop busy", {31'd0, busy}, {31'd0, exp_busy});
    chk("stop line", {31'd0, sda}, 32'd1);
  endtask

  task automatic send_addr(input logic [6:0] a, input logic rw);
    logic [7:0] b;
    b = {a, rw};
    for (int i = 7; i >= 0; i--) clock_bit(b[i], b[i], "addr");
    selected = (a == 7'h42);
    exp_busy = selected ? 1'b1 : 1'b0;
    clock_bit(1'b1, ~selected, "addr_ack");
    if (selected && rw) exp_tx_cnt++;
  endtask

  task automatic write_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) clock_bit(b[i], b[i], "wr_bit");
    clock_bit(1'b1, ~selected, "wr_ack");
    if (selected) exp_rx_q.push_back(b);
  endtask

  task automatic read_byte(input logic [7:0] b, input logic [7:0] next_tx, input logic m_ack);
    for (int i = 7; i >= 0; i--) clock_bit(1'b1, selected ? b[i] : 1'b1, "rd_bit");
    tx_data = next_tx;
    clock_bit(~m_ack, ~m_ack, "rd_ack");
    if (selected) begin
      if (m_ack) exp_tx_cnt++;
      else exp_nack_cnt++;
    end
  endtask

  task automatic check_txn(input string name);
    chk({name, " rx count"}, got_rx_q.size(), exp_rx_q.size());
    while (got_rx_q.size() > 0 && exp_rx_q.size() > 0)
      chk({name, " rx byte"}, {24'd0, got_rx_q.pop_front()}, {24'd0, exp_rx_q.pop_front()});
    got_rx_q.delete();
    exp_rx_q.delete();
    chk({name, " tx_req count"}, tx_cnt, exp_tx_cnt);
    chk({name, " nack count"}, nack_cnt, exp_nack_cnt);
    chk({name, " pulse width"}, width_viol, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    wait_clk(4);
    chk("reset rx_data", {24'd0, rx_data}, 32'h0);
    chk("reset rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("reset tx_req", {31'd0, tx_req}, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset nack_seen", {31'd0, nack_seen}, 32'd0);
    chk("reset sda", {31'd0, sda}, 32'd1);
    rst_n = 1'b1;
    wait_clk(4);

    i2c_start();
    send_addr(7'h42, 1'b0);
    write_byte(8'hA5);
    i2c_stop();
    check_txn("write1");
    chk("write1 rx_data", {24'd0, rx_data}, 32'hA5);
    chk("write1 rx pulses", rx_cnt, 1);

    i2c_start();
    send_addr(7'h17, 1'b0);
    write_byte(8'h55);
    i2c_stop();
    check_txn("mismatch");
    chk("mismatch rx pulses", rx_cnt, 1);

    tx_data = 8'h3C;
    i2c_start();
    send_addr(7'h42, 1'b1);
    read_byte(8'h3C, 8'hC3, 1'b1);
    read_byte(8'hC3, 8'h00, 1'b0);
    for (int i = 0; i < 9; i++) clock_bit(1'b1, 1'b1, "wait_stop");
    i2c_stop();
    check_txn("read2");
    chk("read2 tx_req pulses", tx_cnt, 2);
    chk("read2 nack pulses", nack_cnt, 1);

    i2c_start();
    send_addr(7'h42, 1'b0);
    write_byte(8'h10);
    tx_data = 8'h96;
    i2c_start();
    send_addr(7'h42, 1'b1);
    read_byte(8'h96, 8'h00, 1'b0);
    i2c_stop();
    check_txn("rstart");
    chk("rstart rx_data", {24'd0, rx_data}, 32'h10);

    i2c_start();
    send_addr(7'h42, 1'b0);
    clock_bit(1'b1, 1'b1, "early");
    clock_bit(1'b0, 1'b0, "early");
    clock_bit(1'b1, 1'b1, "early");
    clock_bit(1'b1, 1'b1, "early");
    i2c_stop();
    check_txn("early");
    i2c_start();
    send_addr(7'h42, 1'b0);
    write_byte(8'h5A);
    i2c_stop();
    check_txn("after_early");
    chk("after_early rx_data", {24'd0, rx_data}, 32'h5A);

    i2c_start();
    for (int i = 7; i >= 1; i--) clock_bit(((8'h84 >> i) & 8'h01) != 0, ((8'h84 >> i) & 8'h01) != 0, "rst_addr");
    clock_bit(1'b0, 1'b0, "rst_addr");
    m_low = 1'b0;
    chk("ack driven before reset", {31'd0, sda}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mid reset sda", {31'd0, sda}, 32'd1);
    chk("mid reset rx_data", {24'd0, rx_data}, 32'h0);
    chk("mid reset rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("mid reset tx_req", {31'd0, tx_req}, 32'd0);
    chk("mid reset busy", {31'd0, busy}, 32'd0);
    chk("mid reset nack_seen", {31'd0, nack_seen}, 32'd0);
    exp_busy = 1'b0;
    selected = 1'b0;
    wait_clk(3);
    rst_n = 1'b1;
    scl = 1'b1;
    wait_clk(Q);
    i2c_start();
    send_addr(7'h42, 1'b0);
    write_byte(8'hE7);
    i2c_stop();
    check_txn("after_reset");
    chk("after_reset rx_data", {24'd0, rx_data}, 32'hE7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2c_slave.md
Name: i2c_slave

Overview:
- I2C target (responder) with a 7-bit address, for use with the team's i2c_master or an external controller.
- Oversamples SCL/SDA on the system clock and detects START, repeated START and STOP.
- Matches its address, ACKs, and supports both directions: master-write bytes go out on a valid-pulse interface; master-read bytes are fetched through a request/data interface.
- SDA is open-drain: the block only ever drives low or releases.

Parameters:
- SLAVE_ADDR, 7'h42, 7-bit address this target responds to.

Ports:
- clk  input  1  system clock; must be at least 16x the SCL frequency.
- rst_n  input  1  asynchronous, active-low reset.
- scl  input  1  I2C clock; the block never stretches it.
- sda  inout  1  I2C data; driven 0 when sda_oe=1, else 1'bz.
- rx_data  output  8  last byte written by the master.
- rx_valid  output  1  one-clk pulse when rx_data updates.
- tx_data  input  8  byte to return on a master read; sampled when tx_req pulses.
- tx_req  output  1  one-clk pulse; tx_data is captured in this same cycle.
- busy  output  1  high from an address match until STOP or non-matching repeated START.
- nack_seen  output  1  one-clk pulse when the master NACKs a read byte.

Behaviour:
- Reset values: rx_data=0, rx_valid=0, tx_req=0, busy=0, nack_seen=0, sda released (sda_oe=0), state IDLE. Reset mid-transfer releases SDA immediately (async).
- Input conditioning: 2-flop synchronizers on scl and sda, plus registered previous values.
  - scl_rise/scl_fall: one-cycle edge strobes.
  - START = synced sda falls while synced scl=1; STOP = synced sda rises while synced scl=1.
- Timing rules: SDA is sampled on scl_rise. The block's own SDA output changes only on scl_fall.
- Priority: START/STOP override all state activity in the same cycle.
  - START (incl. repeated) -> ADDR, bit_cnt=0, sda released.
  - STOP -> IDLE, busy=0, sda released.
- States:
  - IDLE: ignore the bus; wait for START.
  - ADDR: shift 8 bits MSB-first on scl_rise (7 address bits, then rw). After the 8th bit, wait for scl_fall.
    - Match: drive sda low -> ADDR_ACK, busy=1.
    - No match: -> WAIT_STOP, busy=0.
  - ADDR_ACK: hold low through the 9th clock. On the next scl_fall:
    - rw=0: release sda -> WRITE.
    - rw=1: pulse tx_req, load shift register from tx_data, drive bit7 (0 -> drive low, 1 -> release) -> READ.
  - WRITE: shift 8 bits on scl_rise. On the 8th rise: rx_data <= byte, rx_valid pulse (same cycle). On the next scl_fall: drive ACK low -> WRITE_ACK. Bytes are always ACKed.
  - WRITE_ACK: on scl_fall release sda, bit_cnt=0 -> WRITE.
  - READ: on each scl_fall after a bit, present the next bit. After bit0's scl_fall, release sda -> READ_ACK.
  - READ_ACK: sample master ACK on scl_rise.
    - ACK (sda=0): on the next scl_fall pulse tx_req, load tx_data, drive bit7 -> READ.
    - NACK: pulse nack_seen -> WAIT_STOP.
  - WAIT_STOP: sda released; leave only on STOP or START.
- Counters: bit_cnt is 3 bits and wraps 7->0 at byte end. The byte-complete flag is raised on the 8th rise.
- Timing: sda_oe changes 3 clk cycles after the physical SCL fall (2 sync + 1 register). This is the source of the >=16x ratio requirement.
- Simultaneous events: START and STOP are mutually exclusive (they need opposite SDA edges). A STOP during ADDR_ACK or WRITE_ACK releases SDA in the same cycle.

Test Plan:
- Write 1 byte: START, addr 0x42+W, data 0xA5, STOP -> ACK on both 9th clocks; rx_data=0xA5 with exactly one rx_valid pulse; busy high between address ACK and STOP, then 0.
- Address mismatch: START, 0x17+W, 0x55, STOP -> SDA never driven low, no rx_valid, busy stays 0.
- Read 2 bytes: tx_data returns 0x3C then 0xC3 on successive tx_req pulses; master ACKs the first byte, NACKs the second -> bus carries 0x3C, 0xC3; exactly 2 tx_req pulses; one nack_seen; state WAIT_STOP until STOP.
- Repeated START: write 0x42+W, byte 0x10, repeated START, 0x42+R, read 1 byte, NACK, STOP -> rx_valid with 0x10, then a correct read; no spurious ACK after the repeated START.
- Early STOP: STOP after 4 data bits of a write -> no rx_valid, SDA released, IDLE, busy=0; the next transaction to 0x42 works normally.
- Reset mid-ACK: assert rst_n=0 while the block drives the ACK low -> sda goes to z immediately; all outputs at reset values.
